lsu_mem_master: RTL and testbench

- Load/store initiator that drives the single-port data memory interface (re, wstrb, byte address, write data, read data) from the CPU load/store stage.
- Accepts one RISC-V load/store request at a time and aligns write data into byte lanes.
- Splits word-boundary-crossing accesses into two word accesses; sign- or zero-extends load results.
- Handles both memory flavours: combinational read (synthesized array) and 1-cycle registered read (BSRAM).

---
 rtl/lsu_mem_master_if.sv | 30 +++
 rtl/lsu_mem_master.sv | 157 +++++++++++++++
 tb/tb_lsu_mem_master.sv | 262 ++++++++++++++++++++++++++
 3 files changed

// File: rtl/lsu_mem_master_if.sv
// Bundle of the load/store request, response and single-port data memory
// signals. The LSU itself uses the master modport.
interface lsu_mem_master_if;
    logic        req_valid;
    logic        req_ready;
    logic        req_we;
    logic [2:0]  req_funct3;
    logic [31:0] req_addr;
    logic [31:0] req_wdata;
    logic        resp_valid;
    logic [31:0] resp_rdata;
    logic        resp_err;
    logic        mem_re;
    logic [3:0]  mem_wstrb;
    logic [31:0] mem_a;
    logic [31:0] mem_wd;
    logic [31:0] mem_rd;

    modport master (
        input  req_valid, req_we, req_funct3, req_addr, req_wdata, mem_rd,
        output req_ready, resp_valid, resp_rdata, resp_err,
        output mem_re, mem_wstrb, mem_a, mem_wd
    );

    modport slave (
        output req_valid, req_we, req_funct3, req_addr, req_wdata, mem_rd,
        input  req_ready, resp_valid, resp_rdata, resp_err,
        input  mem_re, mem_wstrb, mem_a, mem_wd
    );
endinterface

// File: rtl/lsu_mem_master.sv
// RV32 load/store initiator for a single-port data memory: lane alignment,
// split of word-crossing accesses, load extension, 0- or 1-cycle read memories.
module lsu_mem_master #(
    parameter int MEM_LATENCY      = 1,
    parameter int SPLIT_MISALIGNED = 1
) (
    input logic              clk,
    input logic              reset,
    lsu_mem_master_if.master bus
);

    typedef enum logic [2:0] {IDLE, ACC0, WAIT0, ACC1, WAIT1, DONE} state_t;

    state_t      state_q, state_d;
    logic        accept;
    logic        req_illegal, req_err;
    logic [7:0]  base_mask, req_mask;
    logic [31:0] req_wd_lo, req_wd_hi;

    logic        we_q, unsigned_q;
    logic [1:0]  size_q, off_q;
    logic [7:0]  mask_q;
    logic [31:0] wd_hi_q, lo_q, lo_n;
    logic [23:0] hi_q, hi_n;
    logic [31:0] mem_a_q, mem_wd_q, resp_rdata_q;
    logic        resp_err_q;

    logic        split, mem_re_c, sample_lo, sample_hi;
    logic [3:0]  wstrb_c;
    logic [31:0] win, load_val;

    assign accept = bus.req_valid && (state_q == IDLE);
    assign split  = |mask_q[7:4];

    // Request decode: byte mask over two words and lane-shifted store data.
    always_comb begin
        req_illegal = 1'b0;
        base_mask   = 8'h00;
        case (bus.req_funct3)
            3'b000, 3'b100: base_mask = 8'h01;
            3'b001, 3'b101: base_mask = 8'h03;
            3'b010:         base_mask = 8'h0F;
            default:        req_illegal = 1'b1;
        endcase
        if (bus.req_we && bus.req_funct3[2]) req_illegal = 1'b1;
        req_mask = base_mask << bus.req_addr[1:0];
        req_err  = req_illegal || ((SPLIT_MISALIGNED == 0) && (req_mask[7:4] != 4'b0000));
        {req_wd_hi, req_wd_lo} = {32'b0, bus.req_wdata} << {bus.req_addr[1:0], 3'b000};
    end

    always_comb begin
        state_d   = state_q;
        mem_re_c  = 1'b0;
        wstrb_c   = 4'b0000;
        sample_lo = 1'b0;
        sample_hi = 1'b0;
        case (state_q)
            IDLE:  if (accept) state_d = req_err ? DONE : ACC0;
            ACC0: begin
                mem_re_c  = ~we_q;
                wstrb_c   = we_q ? mask_q[3:0] : 4'b0000;
                sample_lo = (MEM_LATENCY == 0);
                if (MEM_LATENCY != 0) state_d = WAIT0;
                else                  state_d = split ? ACC1 : DONE;
            end
            WAIT0: begin
                sample_lo = 1'b1;
                state_d   = split ? ACC1 : DONE;
            end
            ACC1: begin
                mem_re_c  = ~we_q;
                wstrb_c   = we_q ? mask_q[7:4] : 4'b0000;
                sample_hi = (MEM_LATENCY == 0);
                state_d   = (MEM_LATENCY != 0) ? WAIT1 : DONE;
            end
            WAIT1: begin
                sample_hi = 1'b1;
                state_d   = DONE;
            end
            DONE:    state_d = IDLE;
            default: state_d = IDLE;
        endcase

        // The result is formed from this cycle's read data so it is ready in DONE.
        lo_n = sample_lo ? bus.mem_rd : lo_q;
        hi_n = sample_hi ? bus.mem_rd[23:0] : hi_q;
        case (off_q)
            2'd0:    win = lo_n;
            2'd1:    win = {hi_n[7:0],  lo_n[31:8]};
            2'd2:    win = {hi_n[15:0], lo_n[31:16]};
            default: win = {hi_n[23:0], lo_n[31:24]};
        endcase
        case (size_q)
            2'b00:   load_val = {{24{~unsigned_q & win[7]}},  win[7:0]};
            2'b01:   load_val = {{16{~unsigned_q & win[15]}}, win[15:0]};
            default: load_val = win;
        endcase
    end

    always_ff @(posedge clk or posedge reset) begin
        if (reset) state_q <= IDLE;
        else       state_q <= state_d;
    end

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            we_q         <= 1'b0;
            unsigned_q   <= 1'b0;
            size_q       <= 2'b00;
            off_q        <= 2'b00;
            mask_q       <= 8'h00;
            wd_hi_q      <= 32'b0;
            lo_q         <= 32'b0;
            hi_q         <= 24'b0;
            mem_a_q      <= 32'b0;
            mem_wd_q     <= 32'b0;
            resp_rdata_q <= 32'b0;
            resp_err_q   <= 1'b0;
        end else begin
            if (accept) begin
                we_q       <= bus.req_we;
                unsigned_q <= bus.req_funct3[2];
                size_q     <= bus.req_funct3[1:0];
                off_q      <= bus.req_addr[1:0];
                mask_q     <= req_mask;
                wd_hi_q    <= req_wd_hi;
                lo_q       <= 32'b0;
                hi_q       <= 24'b0;
                if (!req_err) begin
                    mem_a_q  <= {bus.req_addr[31:2], 2'b00};
                    mem_wd_q <= req_wd_lo;
                end
            end
            if (sample_lo) lo_q <= bus.mem_rd;
            if (sample_hi) hi_q <= bus.mem_rd[23:0];
            // Second word address wraps naturally at the top of the space.
            if ((state_d == ACC1) && (state_q != ACC1)) begin
                mem_a_q  <= mem_a_q + 32'd4;
                mem_wd_q <= wd_hi_q;
            end
            if ((state_d == DONE) && (state_q != DONE)) begin
                resp_err_q   <= (state_q == IDLE);
                resp_rdata_q <= ((state_q == IDLE) || we_q) ? 32'b0 : load_val;
            end
        end
    end

    assign bus.req_ready  = (state_q == IDLE);
    assign bus.resp_valid = (state_q == DONE);
    assign bus.resp_rdata = resp_rdata_q;
    assign bus.resp_err   = resp_err_q;
    assign bus.mem_re     = mem_re_c;
    assign bus.mem_wstrb  = wstrb_c;
    assign bus.mem_a      = mem_a_q;
    assign bus.mem_wd     = mem_wd_q;

endmodule

// File: tb/tb_lsu_mem_master.sv
// Bench for lsu_mem_master: one instance on a registered-read memory with
// splitting, one on a combinational memory with misalignment flagged as error.
module tb_lsu_mem_master;

    typedef struct {
        logic [31:0] rdata;
        logic        err;
        int          lat;
    } resp_t;

    typedef struct {
        logic [31:0] a;
        logic [3:0]  wstrb;
        logic        re;
        logic [31:0] wd;
    } acc_t;

    logic clk;
    logic reset;
    bit   sel;
    int   checks;
    int   errors;

    resp_t resp_q[$];
    acc_t  acc_q[$];

    lsu_mem_master_if bus1();
    lsu_mem_master_if bus0();

    lsu_mem_master #(.MEM_LATENCY(1), .SPLIT_MISALIGNED(1)) dut1 (
        .clk(clk), .reset(reset), .bus(bus1.master)
    );
    lsu_mem_master #(.MEM_LATENCY(0), .SPLIT_MISALIGNED(0)) dut0 (
        .clk(clk), .reset(reset), .bus(bus0.master)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    // Byte-writable memories: mem1 read through a register, mem0 read combinationally.
    logic [31:0] mem1 [64];
    logic [31:0] mem0 [64];
    logic [31:0] rd1;

    always @(posedge clk) begin
        for (int b = 0; b < 4; b++) begin
            if (bus1.mem_wstrb[b]) mem1[bus1.mem_a[7:2]][8*b +: 8] <= bus1.mem_wd[8*b +: 8];
            if (bus0.mem_wstrb[b]) mem0[bus0.mem_a[7:2]][8*b +: 8] <= bus0.mem_wd[8*b +: 8];
        end
        if (bus1.mem_re) rd1 <= mem1[bus1.mem_a[7:2]];
    end

    assign bus1.mem_rd = rd1;
    assign bus0.mem_rd = mem0[bus0.mem_a[7:2]];

    logic        s_ready, s_valid, s_err, s_re;
    logic [3:0]  s_wstrb;
    logic [31:0] s_rdata, s_a, s_wd;

    assign s_ready = sel ? bus1.req_ready  : bus0.req_ready;
    assign s_valid = sel ? bus1.resp_valid : bus0.resp_valid;
    assign s_err   = sel ? bus1.resp_err   : bus0.resp_err;
    assign s_rdata = sel ? bus1.resp_rdata : bus0.resp_rdata;
    assign s_re    = sel ? bus1.mem_re     : bus0.mem_re;
    assign s_wstrb = sel ? bus1.mem_wstrb  : bus0.mem_wstrb;
    assign s_a     = sel ? bus1.mem_a      : bus0.mem_a;
    assign s_wd    = sel ? bus1.mem_wd     : bus0.mem_wd;

    task automatic checkOutput(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        checks++;
        assert (obs === exp) else begin
            errors++;
            $error("[TB] FAIL %s observed=%h expected=%h", tag, obs, exp);
        end
    endtask

    task automatic driveReq(input bit u, input logic v, input logic we, input logic [2:0] f3,
                            input logic [31:0] addr, input logic [31:0] wdata);
        if (u) begin
            bus1.req_valid = v; bus1.req_we = we; bus1.req_funct3 = f3;
            bus1.req_addr = addr; bus1.req_wdata = wdata;
        end else begin
            bus0.req_valid = v; bus0.req_we = we; bus0.req_funct3 = f3;
            bus0.req_addr = addr; bus0.req_wdata = wdata;
        end
    endtask

    task automatic expectAccess(input logic [31:0] a, input logic [3:0] wstrb, input logic re,
                                input logic [31:0] wd);
        acc_t x;
        x.a = a; x.wstrb = wstrb; x.re = re; x.wd = wd;
        acc_q.push_back(x);
    endtask

    // One request: push the expected response, accept it, then compare every
    // memory cycle and the response against the queues as the DUT produces them.
    task automatic applyStimulus(input bit u, input logic we, input logic [2:0] f3,
                                 input logic [31:0] addr, input logic [31:0] wdata,
                                 input int lat, input logic [31:0] rdata, input logic err);
        resp_t r;
        acc_t  x;
        int    edges;
        bit    seen;
        @(negedge clk);
        sel = u;
        driveReq(u, 1'b1, we, f3, addr, wdata);
        r.rdata = rdata; r.err = err; r.lat = lat;
        resp_q.push_back(r);
        #1 checkOutput("req_ready_idle", 32'(s_ready), 32'd1);
        @(posedge clk);
        edges = 1;
        seen  = 1'b0;
        @(negedge clk);
        driveReq(u, 1'b0, 1'b0, 3'b000, 32'h0, 32'h0);
        for (int cyc = 0; cyc < 12 && !seen; cyc++) begin
            if (s_re || (s_wstrb != 4'b0000)) begin
                checks++;
                assert (acc_q.size() != 0) else begin
                    errors++;
                    $error("[TB] FAIL unexpected_access observed a=%h expected none", s_a);
                end
                if (acc_q.size() != 0) begin
                    x = acc_q.pop_front();
                    checkOutput("mem_a", s_a, x.a);
                    checkOutput("mem_re", 32'(s_re), 32'(x.re));
                    checkOutput("mem_wstrb", 32'(s_wstrb), 32'(x.wstrb));
                    if (!x.re) checkOutput("mem_wd", s_wd, x.wd);
                end
            end
            if (s_valid) begin
                seen = 1'b1;
                r = resp_q.pop_front();
                checkOutput("latency", 32'(edges), 32'(r.lat));
                checkOutput("resp_rdata", s_rdata, r.rdata);
                checkOutput("resp_err", 32'(s_err), 32'(r.err));
            end else begin
                @(posedge clk);
                edges++;
                @(negedge clk);
            end
        end
        checks++;
        assert (seen) else begin
            errors++;
            $error("[TB] FAIL resp_timeout observed=none expected=resp_valid");
        end
        checks++;
        assert (acc_q.size() == 0) else begin
            errors++;
            $error("[TB] FAIL missing_access observed=%0d expected=0 pending", acc_q.size());
        end
        resp_q = {};
        acc_q  = {};
        @(posedge clk);
        @(negedge clk);
        checkOutput("resp_pulse_end", 32'(s_valid), 32'd0);
    endtask

    initial begin
        checks = 0;
        errors = 0;
        sel    = 1'b1;
        reset  = 1'b1;
        driveReq(1'b1, 1'b0, 1'b0, 3'b000, 32'h0, 32'h0);
        driveReq(1'b0, 1'b0, 1'b0, 3'b000, 32'h0, 32'h0);
        repeat (2) @(posedge clk);
        @(negedge clk);
        checkOutput("rst_ready", 32'(s_ready), 32'd1);
        checkOutput("rst_valid", 32'(s_valid), 32'd0);
        checkOutput("rst_err", 32'(s_err), 32'd0);
        checkOutput("rst_rdata", s_rdata, 32'd0);
        checkOutput("rst_re", 32'(s_re), 32'd0);
        checkOutput("rst_wstrb", 32'(s_wstrb), 32'd0);
        checkOutput("rst_a", s_a, 32'd0);
        checkOutput("rst_wd", s_wd, 32'd0);
        reset = 1'b0;

        $display("[TB] registered-read memory, splitting enabled");
        expectAccess(32'h10, 4'b1111, 1'b0, 32'hDEADBEEF);
        applyStimulus(1'b1, 1'b1, 3'b010, 32'h10, 32'hDEADBEEF, 3, 32'h0, 1'b0);
        expectAccess(32'h10, 4'b0000, 1'b1, 32'h0);
        applyStimulus(1'b1, 1'b0, 3'b010, 32'h10, 32'h0, 3, 32'hDEADBEEF, 1'b0);

        expectAccess(32'h20, 4'b1111, 1'b0, 32'h80018000);
        applyStimulus(1'b1, 1'b1, 3'b010, 32'h20, 32'h80018000, 3, 32'h0, 1'b0);
        expectAccess(32'h20, 4'b0000, 1'b1, 32'h0);
        applyStimulus(1'b1, 1'b0, 3'b000, 32'h21, 32'h0, 3, 32'hFFFFFF80, 1'b0);
        expectAccess(32'h20, 4'b0000, 1'b1, 32'h0);
        applyStimulus(1'b1, 1'b0, 3'b100, 32'h21, 32'h0, 3, 32'h00000080, 1'b0);
        expectAccess(32'h20, 4'b0000, 1'b1, 32'h0);
        applyStimulus(1'b1, 1'b0, 3'b101, 32'h22, 32'h0, 3, 32'h00008001, 1'b0);

        expectAccess(32'h20, 4'b1000, 1'b0, 32'hA5000000);
        applyStimulus(1'b1, 1'b1, 3'b000, 32'h23, 32'h000000A5, 3, 32'h0, 1'b0);
        expectAccess(32'h20, 4'b0000, 1'b1, 32'h0);
        applyStimulus(1'b1, 1'b0, 3'b010, 32'h20, 32'h0, 3, 32'hA5018000, 1'b0);

        expectAccess(32'h04, 4'b1111, 1'b0, 32'hAAAAAAAA);
        applyStimulus(1'b1, 1'b1, 3'b010, 32'h04, 32'hAAAAAAAA, 3, 32'h0, 1'b0);
        expectAccess(32'h08, 4'b1111, 1'b0, 32'hAAAAAAAA);
        applyStimulus(1'b1, 1'b1, 3'b010, 32'h08, 32'hAAAAAAAA, 3, 32'h0, 1'b0);
        expectAccess(32'h04, 4'b1100, 1'b0, 32'h33440000);
        expectAccess(32'h08, 4'b0011, 1'b0, 32'h00001122);
        applyStimulus(1'b1, 1'b1, 3'b010, 32'h06, 32'h11223344, 5, 32'h0, 1'b0);
        expectAccess(32'h04, 4'b0000, 1'b1, 32'h0);
        expectAccess(32'h08, 4'b0000, 1'b1, 32'h0);
        applyStimulus(1'b1, 1'b0, 3'b010, 32'h06, 32'h0, 5, 32'h11223344, 1'b0);

        expectAccess(32'hFFFFFFFC, 4'b1000, 1'b0, 32'hEF000000);
        expectAccess(32'h00000000, 4'b0001, 1'b0, 32'h000000BE);
        applyStimulus(1'b1, 1'b1, 3'b001, 32'hFFFFFFFF, 32'h0000BEEF, 5, 32'h0, 1'b0);
        expectAccess(32'hFFFFFFFC, 4'b0000, 1'b1, 32'h0);
        expectAccess(32'h00000000, 4'b0000, 1'b1, 32'h0);
        applyStimulus(1'b1, 1'b0, 3'b001, 32'hFFFFFFFF, 32'h0, 5, 32'hFFFFBEEF, 1'b0);

        applyStimulus(1'b1, 1'b0, 3'b011, 32'h10, 32'h0, 1, 32'h0, 1'b1);
        applyStimulus(1'b1, 1'b1, 3'b100, 32'h10, 32'h55, 1, 32'h0, 1'b1);

        $display("[TB] reset during a load wait cycle");
        @(negedge clk);
        sel = 1'b1;
        driveReq(1'b1, 1'b1, 1'b0, 3'b010, 32'h10, 32'h0);
        @(posedge clk);
        @(negedge clk);
        driveReq(1'b1, 1'b0, 1'b0, 3'b000, 32'h0, 32'h0);
        checkOutput("abort_acc0_re", 32'(s_re), 32'd1);
        @(posedge clk);
        #1 reset = 1'b1;
        #1;
        checkOutput("abort_ready", 32'(s_ready), 32'd1);
        checkOutput("abort_re", 32'(s_re), 32'd0);
        checkOutput("abort_a", s_a, 32'd0);
        checkOutput("abort_wd", s_wd, 32'd0);
        checkOutput("abort_valid", 32'(s_valid), 32'd0);
        checkOutput("abort_rdata", s_rdata, 32'd0);
        @(negedge clk);
        reset = 1'b0;
        for (int i = 0; i < 4; i++) begin
            @(negedge clk);
            checkOutput("abort_no_resp", 32'(s_valid), 32'd0);
        end
        expectAccess(32'h10, 4'b0000, 1'b1, 32'h0);
        applyStimulus(1'b1, 1'b0, 3'b010, 32'h10, 32'h0, 3, 32'hDEADBEEF, 1'b0);

        $display("[TB] combinational-read memory, misalignment is an error");
        expectAccess(32'h10, 4'b1111, 1'b0, 32'h12345678);
        applyStimulus(1'b0, 1'b1, 3'b010, 32'h10, 32'h12345678, 2, 32'h0, 1'b0);
        expectAccess(32'h10, 4'b0000, 1'b1, 32'h0);
        applyStimulus(1'b0, 1'b0, 3'b010, 32'h10, 32'h0, 2, 32'h12345678, 1'b0);
        expectAccess(32'h10, 4'b0010, 1'b0, 32'h00005A00);
        applyStimulus(1'b0, 1'b1, 3'b000, 32'h11, 32'h0000005A, 2, 32'h0, 1'b0);
        expectAccess(32'h10, 4'b0000, 1'b1, 32'h0);
        applyStimulus(1'b0, 1'b0, 3'b100, 32'h11, 32'h0, 2, 32'h0000005A, 1'b0);
        applyStimulus(1'b0, 1'b0, 3'b001, 32'h03, 32'h0, 1, 32'h0, 1'b1);
        applyStimulus(1'b0, 1'b0, 3'b011, 32'h00, 32'h0, 1, 32'h0, 1'b1);
        applyStimulus(1'b0, 1'b0, 3'b010, 32'h12, 32'h0, 1, 32'h0, 1'b1);

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule
